calc_n_engine: RTL and testbench
================================

Name: calc_n_engine

Overview:
- Parametrised successor to the 4-port calculator: NUM_PORTS request ports, DATA_W-bit operands, TAG_W-bit tags.
- Each port captures a two-cycle request: command plus operand 1, then operand 2.
- A round-robin arbiter issues one captured request per cycle to a shared add/sub/shift ALU.
- The tagged response returns on the originating port. The block sits between requester-side bus adapters and the calc top level.

Parameters:
- NUM_PORTS, 4, number of request/response ports (2..8).
- DATA_W, 32, operand and result width (8..64, power of 2).
- TAG_W, 2, tag width echoed back with the response.

Ports:
- c_clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_cmd_in  in  NUM_PORTS*4  per-port command (port p at [4p+3:4p]).
- req_data_in  in  NUM_PORTS*DATA_W  per-port operand.
- req_tag_in  in  NUM_PORTS*TAG_W  per-port tag, sampled with the command.
- out_resp  out  NUM_PORTS*2  per-port response code: 0 none, 1 success, 2 error.
- out_data  out  NUM_PORTS*DATA_W  per-port result.
- out_tag  out  NUM_PORTS*TAG_W  per-port echoed tag.
- busy  out  NUM_PORTS  per-port flag: 1 while the port's FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All outputs reset to 0.
  - All port FSMs go to IDLE and the arbiter pointer goes to 0.
  - Any in-flight request is discarded and never answered.
- Commands: 0 NOP, 1 ADD, 2 SUB, 5 SHL, 6 SHR. Any other nonzero command is invalid.
- Per-port FSM (states IDLE, OP2, PEND):
  - IDLE: when cmd != 0 at a rising edge, latch cmd, tag and data as op1, then go to OP2. cmd == 0 means stay in IDLE.
  - OP2: at the next edge, latch data as op2 unconditionally and go to PEND. The cmd input is ignored during this cycle.
  - PEND: wait for a grant; on grant, return to IDLE. Commands presented while in OP2 or PEND are ignored and dropped.
- Arbiter:
  - Round-robin over ports in PEND, one grant per cycle.
  - Search starts at the pointer. After a grant, the pointer moves to granted+1, wrapping NUM_PORTS-1 back to 0.
  - If no port is pending, the pointer holds.
- Execute and response:
  - The granted request is computed and registered. The response is driven on the originating port for exactly one cycle; resp returns to 0 afterwards.
  - Uncontended latency: cmd sampled at edge k, op2 at k+1, grant at k+2, resp/data/tag valid after edge k+3 (visible in cycle k+3..k+4).
  - Contention adds one cycle per port served ahead.
- Arithmetic:
  - ADD: on carry-out, resp=2 and data=0.
  - SUB: if op2 > op1 (unsigned), resp=2 and data=0.
  - SHL/SHR: logical shift by op2[$clog2(DATA_W)-1:0]; upper op2 bits are ignored; resp=1.
  - Invalid command: resp=2, data=0, tag echoed.
- A port may present a new command in the cycle immediately after its grant edge (FSM is IDLE), so back-to-back requests overlap with the prior response.
- Simultaneous events: all ports entering PEND in the same cycle are served in pointer order, with no starvation. The worst-case wait is NUM_PORTS-1 cycles.

Optional Feature:
- CALC_OUT_REG_EN: adds a second output register stage for timing closure.
  - Defined: every response arrives one cycle later (uncontended latency 4 edges); throughput is unchanged.
  - Undefined: latency as above.

Decomposition:
- Package calc_n_pkg holds:
  - cmd_e enum (NOP, ADD, SUB, SHL, SHR);
  - resp_e enum (NONE, OK, ERR);
  - port_state_e enum (IDLE, OP2, PEND);
  - a req_t struct {cmd, op1, op2, tag}.
- Sub-module calc_n_rr_arb: a parametrised NUM_PORTS round-robin arbiter with pointer register, producing a one-hot grant. It is instantiated once.

Test Plan:
- Reset, then port0 ADD: cmd=1, tag=2, data 0x30 then 0x20 → out_resp[0]=1, out_data=0x50, out_tag=2 exactly 3 edges after cmd, held one cycle.
- Port1 SUB 0x10 − 0x20 → resp=2, data=0. Port2 ADD 0xFFFFFFFF + 1 → resp=2, data=0 (DATA_W=32).
- Port3 SHL 0x1 by 0x24 → shift amount is 4, resp=1, data=0x10. SHR 0x80 by 3 → data=0x10.
- All 4 ports issue ADD in the same cycle with pointer at 0 → responses on ports 0, 1, 2, 3 at edges k+3, k+4, k+5, k+6. The next simultaneous burst is served in order 0, 1, 2, 3 again, since the pointer returned to 0.
- Port0 issues cmd=4'hF tag=1 → resp=2, data=0, tag=1. A command issued on port0 while it is in PEND is dropped, with no extra response.
- Assert reset while port1 is in PEND → no response ever on port1, busy=0 immediately. A new request after reset completes normally.

Source files
------------

// File: rtl/calc_n_engine_pkg.sv
// -----------------------------------------------------------------------------
// calc_n_pkg
// Shared types for the N-port calculator engine: command, response and
// per-port state encodings, plus the captured request record.
// The request record is sized for the widest supported configuration
// (64-bit operands, 8-bit tags); each user slices the low DATA_W / TAG_W bits.
// -----------------------------------------------------------------------------
package calc_n_pkg;

  localparam int CMD_W      = 4;
  localparam int RESP_W     = 2;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_TAG_W  = 8;

  typedef enum logic [CMD_W-1:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    PEND = 2'd2
  } port_state_e;

  // cmd is kept as raw bits so that invalid codes survive until execute,
  // where they are answered with ERR.
  typedef struct packed {
    logic [CMD_W-1:0]      cmd;
    logic [MAX_DATA_W-1:0] op1;
    logic [MAX_DATA_W-1:0] op2;
    logic [MAX_TAG_W-1:0]  tag;
  } req_t;

endpackage

// File: rtl/calc_n_engine_if.sv
// -----------------------------------------------------------------------------
// calc_n_engine_if
// Bundles the per-port request and response buses of calc_n_engine.
// Port p occupies [4p+3:4p] of req_cmd_in, [DATA_W*p +: DATA_W] of the data
// buses, [TAG_W*p +: TAG_W] of the tag buses, [2p+1:2p] of out_resp and bit p
// of busy.
//   master : requester side (drives requests, observes responses)
//   slave  : engine side (observes requests, drives responses and busy)
// -----------------------------------------------------------------------------
interface calc_n_engine_if
  import calc_n_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2
) ();

  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in;
  logic [NUM_PORTS*RESP_W-1:0] out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS*TAG_W-1:0]  out_tag;
  logic [NUM_PORTS-1:0]        busy;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  out_resp, out_data, out_tag, busy
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, busy
  );

endinterface

// File: rtl/calc_n_engine_rr_arb.sv
// -----------------------------------------------------------------------------
// calc_n_rr_arb
// Round-robin arbiter over NUM_PORTS requesters. The search for a requester
// starts at the pointer; after a grant the pointer moves to granted+1
// (wrapping), and it holds when nothing is requested.
// Ports:
//   clk, rst : clock and asynchronous active-high reset (pointer -> 0)
//   req      : per-port request vector
//   gnt      : one-hot grant (combinational from req and pointer)
//   gnt_vld  : a grant is issued this cycle
//   gnt_idx  : index of the granted port
// -----------------------------------------------------------------------------
module calc_n_rr_arb #(
  parameter int NUM_PORTS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         req,
  output logic [NUM_PORTS-1:0]         gnt,
  output logic                         gnt_vld,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_idx
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [PTR_W-1:0] ptr;

  always_comb begin
    int j;
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/calc_n_engine.sv
// -----------------------------------------------------------------------------
// calc_n_engine
// NUM_PORTS-port calculator. Each port captures a two-cycle request
// (command + operand 1, then operand 2), waits for a round-robin grant, and
// the shared add/sub/shift ALU answers on the originating port with a
// one-cycle response pulse carrying result and echoed tag.
// Ports:
//   c_clk : clock, rising edge
//   reset : asynchronous active-high reset; clears port FSMs, arbiter pointer,
//           in-flight work and all outputs
//   bus   : calc_n_engine_if.slave (request inputs, response outputs, busy)
// Configuration:
//   CALC_OUT_REG_EN : when defined, adds a register stage between the ALU and
//                     the port outputs (one extra cycle of latency, same
//                     throughput). Undefined by default.
// Limits: TAG_W up to 8, DATA_W 8..64 (power of two), NUM_PORTS 2..8.
// -----------------------------------------------------------------------------
module calc_n_engine
  import calc_n_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2
) (
  input  logic             c_clk,
  input  logic             reset,
  calc_n_engine_if.slave   bus
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ZERO = '0;

  // Returns {resp, result}. Operands are unsigned.
  function automatic logic [RESP_W+DATA_W-1:0] alu(
    input logic [CMD_W-1:0]  cmd,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0]   sum;
    logic [SH_W-1:0]   sh;
    sum = {1'b0, a} + {1'b0, b};
    sh  = b[SH_W-1:0];
    case (cmd)
      ADD:     return sum[DATA_W] ? {ERR, ZERO} : {OK, sum[DATA_W-1:0]};
      SUB:     return (b > a) ? {ERR, ZERO} : {OK, a - b};
      SHL:     return {OK, a << sh};
      SHR:     return {OK, a >> sh};
      default: return {ERR, ZERO};
    endcase
  endfunction

  port_state_e          state [NUM_PORTS];
  req_t                 req_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend;
  logic [NUM_PORTS-1:0] gnt;
  logic                 gnt_vld;
  logic [PTR_W-1:0]     gnt_idx;

  always_comb begin
    pend = '0;
    for (int p = 0; p < NUM_PORTS; p++) pend[p] = (state[p] == PEND);
  end

  calc_n_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk     (c_clk),
    .rst     (reset),
    .req     (pend),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Per-port request FSMs. Commands seen outside IDLE are dropped.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) state[p] <= IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case (state[p])
          IDLE:    if (bus.req_cmd_in[CMD_W*p +: CMD_W] != '0) state[p] <= OP2;
          OP2:     state[p] <= PEND;
          PEND:    if (gnt[p]) state[p] <= IDLE;
          default: state[p] <= IDLE;
        endcase
      end
    end
  end

  // Request capture (data path, not reset).
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (state[p] == IDLE && bus.req_cmd_in[CMD_W*p +: CMD_W] != '0) begin
        req_q[p].cmd <= bus.req_cmd_in[CMD_W*p +: CMD_W];
        req_q[p].op1 <= MAX_DATA_W'(bus.req_data_in[DATA_W*p +: DATA_W]);
        req_q[p].tag <= MAX_TAG_W'(bus.req_tag_in[TAG_W*p +: TAG_W]);
      end else if (state[p] == OP2) begin
        req_q[p].op2 <= MAX_DATA_W'(bus.req_data_in[DATA_W*p +: DATA_W]);
      end
    end
  end

  // ---- stage p0: granted request registered ----
  logic             vld_p0;
  req_t             req_p0;
  logic [PTR_W-1:0] port_p0;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= gnt_vld;
  end

  always_ff @(posedge c_clk) begin
    if (gnt_vld) begin
      req_p0  <= req_q[gnt_idx];
      port_p0 <= gnt_idx;
    end
  end

  logic [RESP_W+DATA_W-1:0] alu_res;
  resp_e                    alu_resp;
  logic [DATA_W-1:0]        alu_data;
  logic                     unused_req_bits;

  assign alu_res  = alu(req_p0.cmd, req_p0.op1[DATA_W-1:0], req_p0.op2[DATA_W-1:0]);
  assign alu_resp = resp_e'(alu_res[RESP_W+DATA_W-1:DATA_W]);
  assign alu_data = alu_res[DATA_W-1:0];
  // Upper bits of the wide request record are never consumed.
  assign unused_req_bits = ^{req_p0.op1, req_p0.op2, req_p0.tag};

  logic              fin_vld;
  resp_e             fin_resp;
  logic [DATA_W-1:0] fin_data;
  logic [TAG_W-1:0]  fin_tag;
  logic [PTR_W-1:0]  fin_port;

`ifdef CALC_OUT_REG_EN
  // ---- stage p1: optional retiming register after the ALU ----
  logic              vld_p1;
  resp_e             resp_p1;
  logic [DATA_W-1:0] data_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [PTR_W-1:0]  port_p1;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge c_clk) begin
    resp_p1 <= alu_resp;
    data_p1 <= alu_data;
    tag_p1  <= req_p0.tag[TAG_W-1:0];
    port_p1 <= port_p0;
  end

  assign fin_vld  = vld_p1;
  assign fin_resp = resp_p1;
  assign fin_data = data_p1;
  assign fin_tag  = tag_p1;
  assign fin_port = port_p1;
`else
  assign fin_vld  = vld_p0;
  assign fin_resp = alu_resp;
  assign fin_data = alu_data;
  assign fin_tag  = req_p0.tag[TAG_W-1:0];
  assign fin_port = port_p0;
`endif

  // ---- output stage: per-port response registers ----
  // resp pulses for one cycle; data and tag hold until the next response.
  resp_e             resp_q [NUM_PORTS];
  logic [DATA_W-1:0] data_q [NUM_PORTS];
  logic [TAG_W-1:0]  tag_q  [NUM_PORTS];

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_q[p] <= NONE;
        data_q[p] <= '0;
        tag_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (fin_vld && fin_port == PTR_W'(p)) begin
          resp_q[p] <= fin_resp;
          data_q[p] <= fin_data;
          tag_q[p]  <= fin_tag;
        end else begin
          resp_q[p] <= NONE;
        end
      end
    end
  end

  always_comb begin
    bus.out_resp = '0;
    bus.out_data = '0;
    bus.out_tag  = '0;
    bus.busy     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.out_resp[RESP_W*p +: RESP_W] = resp_q[p];
      bus.out_data[DATA_W*p +: DATA_W] = data_q[p];
      bus.out_tag[TAG_W*p +: TAG_W]    = tag_q[p];
      bus.busy[p]                      = (state[p] != IDLE);
    end
  end

endmodule

// File: tb/tb_calc_n_engine.sv
// -----------------------------------------------------------------------------
// tb_calc_n_engine
// Directed bench for calc_n_engine (4 ports, 32-bit data, 2-bit tags).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_calc_n_engine;
  import calc_n_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;
`ifdef CALC_OUT_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  calc_n_engine_if #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

  calc_n_engine #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick;
    @(posedge c_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [3:0] cmd, input logic [TW-1:0] tag,
                         input logic [DW-1:0] data);
    bus.req_cmd_in[4*p +: 4]   = cmd;
    bus.req_tag_in[TW*p +: TW] = tag;
    bus.req_data_in[DW*p +: DW] = data;
  endtask

  // One uncontended request: response expected exactly LAT edges after cmd.
  task automatic run_single(input string name, input int p, input logic [3:0] cmd,
                            input logic [TW-1:0] tag, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [1:0] exp_resp,
                            input logic [DW-1:0] exp_data);
    set_req(p, cmd, tag, a);
    tick;
    check({name, "_busy"}, bus.busy[p], 1);
    set_req(p, 4'd0, '0, b);
    tick;
    set_req(p, 4'd0, '0, '0);
    repeat (LAT - 2) tick;
    check({name, "_early"}, bus.out_resp[2*p +: 2], 0);
    tick;
    check({name, "_resp"}, bus.out_resp[2*p +: 2], exp_resp);
    check({name, "_data"}, bus.out_data[DW*p +: DW], exp_data);
    check({name, "_tag"}, bus.out_tag[TW*p +: TW], tag);
    tick;
    check({name, "_resp_clr"}, bus.out_resp[2*p +: 2], 0);
    check({name, "_idle"}, bus.busy[p], 0);
  endtask

  // All ports issue ADD together; served in order 0..3 one cycle apart.
  task automatic burst(input string name, input logic [DW-1:0] base,
                       input logic [DW-1:0] inc, input logic [TW-1:0] txor);
    logic [7:0] ev;
    for (int p = 0; p < NP; p++) set_req(p, 4'd1, TW'(p) ^ txor, base * DW'(p + 1));
    tick;
    for (int p = 0; p < NP; p++) set_req(p, 4'd0, '0, inc + DW'(p));
    tick;
    for (int p = 0; p < NP; p++) set_req(p, 4'd0, '0, '0);
    repeat (LAT - 2) tick;
    for (int i = 0; i < NP; i++) begin
      tick;
      ev = 8'h01 << (2 * i);
      check({name, "_resp_vec"}, bus.out_resp, ev);
      check({name, "_data"}, bus.out_data[DW*i +: DW], base * DW'(i + 1) + inc + DW'(i));
      check({name, "_tag"}, bus.out_tag[TW*i +: TW], TW'(i) ^ txor);
    end
    tick;
    check({name, "_resp_clr"}, bus.out_resp, 0);
    check({name, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    bus.req_cmd_in  = '0;
    bus.req_data_in = '0;
    bus.req_tag_in  = '0;
    reset = 1'b1;
    repeat (3) @(posedge c_clk);
    #1;
    check("rst_resp", bus.out_resp, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_tag", bus.out_tag, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    tick;

    run_single("add0",    0, 4'd1, 2'd2, 32'h30,       32'h20, 2'd1, 32'h50);
    run_single("sub_err", 1, 4'd2, 2'd1, 32'h10,       32'h20, 2'd2, 32'h0);
    run_single("sub_ok",  1, 4'd2, 2'd3, 32'h50,       32'h20, 2'd1, 32'h30);
    run_single("add_ovf", 2, 4'd1, 2'd0, 32'hFFFFFFFF, 32'h1,  2'd2, 32'h0);
    run_single("add_max", 2, 4'd1, 2'd1, 32'hFFFFFFFE, 32'h1,  2'd1, 32'hFFFFFFFF);
    run_single("shl",     3, 4'd5, 2'd2, 32'h1,        32'h24, 2'd1, 32'h10);
    run_single("shr",     3, 4'd6, 2'd3, 32'h80,       32'h3,  2'd1, 32'h10);

    // Pointer is back at 0 after the port 3 grants.
    burst("burst1", 32'h100,  32'h1,  2'd0);
    burst("burst2", 32'h1000, 32'h11, 2'd3);

    run_single("invalid", 0, 4'hF, 2'd1, 32'h5, 32'h6, 2'd2, 32'h0);

    // Command held through OP2 and PEND must be dropped.
    set_req(0, 4'd1, 2'd3, 32'h1);
    tick;
    set_req(0, 4'd1, 2'd0, 32'h2);
    tick;
    set_req(0, 4'd1, 2'd0, 32'h9);
    tick;
    set_req(0, 4'd0, 2'd0, 32'h0);
    check("drop_busy", bus.busy[0], 0);
    repeat (LAT - 3) tick;
    tick;
    check("drop_resp", bus.out_resp[1:0], 1);
    check("drop_data", bus.out_data[DW-1:0], 32'h3);
    check("drop_tag", bus.out_tag[TW-1:0], 2'd3);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("drop_no_extra", bus.out_resp, 0);
      check("drop_stay_idle", bus.busy, 0);
    end

    // Reset while port 1 is pending: request vanishes.
    set_req(1, 4'd2, 2'd2, 32'h40);
    tick;
    set_req(1, 4'd0, 2'd0, 32'h8);
    tick;
    set_req(1, 4'd0, 2'd0, 32'h0);
    check("rstp_pend_busy", bus.busy[1], 1);
    #1 reset = 1'b1;
    #1;
    check("rstp_busy_now", bus.busy, 0);
    check("rstp_resp_now", bus.out_resp, 0);
    tick;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("rstp_no_resp", bus.out_resp, 0);
    end
    run_single("post_rst", 1, 4'd1, 2'd1, 32'h7, 32'h8, 2'd1, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
